// File: rtl/sbox_mix_pkg.sv
// Shared types and constants for the S-box / MixColumn / per-bit select datapath.
// Also provides the GF(2^4) multiply used by the mix layer.
package sbox_mix_pkg;

    typedef logic [3:0] nibble_t;

    localparam nibble_t SBOX_TABLE [16] = '{
        4'h1, 4'h3, 4'h0, 4'h2, 4'h7, 4'hE, 4'h4, 4'hD,
        4'h9, 4'hA, 4'hC, 4'h6, 4'hF, 4'h5, 4'h8, 4'hB
    };

    // x^4 + x + 1
    localparam logic [4:0] RED_POLY = 5'h13;

    // Row 0 of the circulant mix matrix; row j is this row rotated right by j.
    localparam nibble_t MIX_ROW0 [4] = '{4'h2, 4'h3, 4'h1, 4'h1};

    // Shift-and-add multiply, reducing by RED_POLY whenever bit 3 shifts out.
    function automatic nibble_t gf_mul(input nibble_t a, input nibble_t b);
        nibble_t prod;
        nibble_t acc;
        prod = 4'h0;
        acc  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                prod = prod ^ acc;
            end else begin
                prod = prod;
            end
            acc = {acc[2:0], 1'b0} ^ (acc[3] ? RED_POLY[3:0] : 4'h0);
        end
        return prod;
    endfunction

endpackage

// File: rtl/sbox_mix_mux_if.sv
// Input/output bundle of sbox_mix_mux: one valid-qualified input beat and the
// registered result. The slave modport is the DUT side.
interface sbox_mix_mux_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic [15:0] in_sel;
    logic        out_valid;
    logic [15:0] out_data;

    modport master (
        output in_valid, in_data, in_sel,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel,
        output out_valid, out_data
    );
endinterface

// File: rtl/sbox_mix_mux_nibble_sbox.sv
// Combinational 4-bit S-box lookup.
module nibble_sbox
    import sbox_mix_pkg::*;
(
    input  nibble_t nib_i,
    output nibble_t nib_o
);

    assign nib_o = SBOX_TABLE[nib_i];

endmodule

// File: rtl/sbox_mix_mux.sv
// S-box layer, GF(2^4) circulant mix, then per-bit select between mixed and
// substituted bits. Define SBOX_MIX_PIPE_EN to register between S-box and mix.
module sbox_mix_mux
    import sbox_mix_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    sbox_mix_mux_if.slave bus
);

    logic [15:0] t_s;
    logic [15:0] mix_t_s;
    logic [15:0] mix_sel_s;
    logic        mix_v_s;
    logic [15:0] mix_s;
    logic [15:0] sel_data_s;
    logic        out_valid_q;
    logic [15:0] out_data_q;
    logic [15:0] out_data_d;

    // nibble0 sits in the top bits, so instance g handles bits [15-4g -: 4]
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        nibble_sbox u_sbox (
            .nib_i (bus.in_data[15-4*g -: 4]),
            .nib_o (t_s[15-4*g -: 4])
        );
    end

`ifdef SBOX_MIX_PIPE_EN
    logic [15:0] t_q;
    logic [15:0] t_d;
    logic [15:0] sel_q;
    logic [15:0] sel_d;
    logic        v_q;

    // Stage-1 load: capture only on a valid beat, hold otherwise
    always_comb begin
        t_d   = t_q;
        sel_d = sel_q;
        if (bus.in_valid) begin
            t_d   = t_s;
            sel_d = bus.in_sel;
        end else begin
            t_d   = t_q;
            sel_d = sel_q;
        end
    end

    // Stage-1 registers between S-box and mix
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q   <= 16'h0000;
            sel_q <= 16'h0000;
            v_q   <= 1'b0;
        end else begin
            t_q   <= t_d;
            sel_q <= sel_d;
            v_q   <= bus.in_valid;
        end
    end

    assign mix_t_s   = t_q;
    assign mix_sel_s = sel_q;
    assign mix_v_s   = v_q;
`else
    assign mix_t_s   = t_s;
    assign mix_sel_s = bus.in_sel;
    assign mix_v_s   = bus.in_valid;
`endif

    // Circulant mix (coefficient of row j, column k is MIX_ROW0[k-j mod 4]) and bit select
    always_comb begin
        mix_s = 16'h0000;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 4; k++) begin
                mix_s[15-4*j -: 4] = mix_s[15-4*j -: 4]
                                   ^ gf_mul(MIX_ROW0[2'(k - j)], mix_t_s[15-4*k -: 4]);
            end
        end
        sel_data_s = (mix_sel_s & mix_s) | (~mix_sel_s & mix_t_s);
    end

    // Output data loads only on a valid beat
    always_comb begin
        out_data_d = out_data_q;
        if (mix_v_s) begin
            out_data_d = sel_data_s;
        end else begin
            out_data_d = out_data_q;
        end
    end

    // Output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
        end else begin
            out_valid_q <= mix_v_s;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_sbox_mix_mux.sv
// Scoreboard bench for sbox_mix_mux: directed vectors with hand-computed results,
// checked in order and at the expected cycle by an independent monitor.
module tb_sbox_mix_mux;

`ifdef SBOX_MIX_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    sbox_mix_mux_if bus ();

    sbox_mix_mux dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Monitor: every valid output must match the oldest expectation, at its cycle.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h, none expected (cycle %0d)", bus.out_data, cyc);
            end else begin
                e = sb.pop_front();
                if (bus.out_data !== e.data) begin
                    errors++;
                    $display("FAIL out_data: got %h, expected %h", bus.out_data, e.data);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL latency: output at cycle %0d, expected cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [15:0] s, input logic [15:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = s;
        x.data = e;
        x.cyc  = cyc + LAT;
        sb.push_back(x);
    endtask

    task automatic idle(input logic [15:0] d);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = d;
        bus.in_sel   = ~d;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs still pending, expected 0", sb.size());
        end
    endtask

    initial begin
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        bus.in_sel   = 16'h0000;

        #3;
        chk("reset_out_valid", {15'h0000, bus.out_valid}, 16'h0000);
        chk("reset_out_data", bus.out_data, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send(16'h0000, 16'h0000, 16'h1111);
        idle(16'h0000);
        send(16'h0123, 16'hFFFF, 16'h5544);
        send(16'h0123, 16'h0000, 16'h1302);
        send(16'h0123, 16'hF0F0, 16'h5342);
        idle(16'h0000);
        drain();

        // Back-to-back beats
        send(16'h0000, 16'hFFFF, 16'h1111);
        send(16'hFFFF, 16'hFFFF, 16'hBBBB);
        send(16'h0123, 16'hFFFF, 16'h5544);
        idle(16'hA5A5);
        drain();

        // Invalid beats with changing data: output holds
        for (int i = 0; i < 4; i++) begin
            idle(16'h3C3C ^ 16'(i * 16'h1111));
            @(negedge clk);
            chk("hold_out_valid", {15'h0000, bus.out_valid}, 16'h0000);
            chk("hold_out_data", bus.out_data, 16'h5544);
        end

        // Async reset with a transaction in flight: it must never appear
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        bus.in_sel   = 16'hFFFF;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {15'h0000, bus.out_valid}, 16'h0000);
        chk("async_rst_out_data", bus.out_data, 16'h0000);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_out_valid", {15'h0000, bus.out_valid}, 16'h0000);
        end

        send(16'h0000, 16'h0000, 16'h1111);
        idle(16'h0000);
        drain();
        chk("post_rst_hold_data", bus.out_data, 16'h1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
